// File: rtl/packet_buffer_pkg.sv
// Shared types and helpers for the lane-split packet buffer and its egress merger.
package packet_buffer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } merger_state_t;

  localparam int BYTE_WIDTH = 8;

  // Bit offset of byte slot k in a word of the given width; slot 0 is the MSB byte.
  function automatic int byte_slot_lo(input int k, input int width);
    return width - BYTE_WIDTH * (k + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_LANES = 8
) (
  input  logic [NUM_LANES-1:0]         req,
  input  logic [$clog2(NUM_LANES)-1:0] ptr,
  output logic [NUM_LANES-1:0]         grant,
  output logic [$clog2(NUM_LANES)-1:0] grant_idx,
  output logic                         grant_valid
);

  localparam int LANE_IDX_WIDTH = $clog2(NUM_LANES);

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    // Outer loop walks priority order starting at ptr; inner loop maps it to a lane.
    for (int i = 0; i < NUM_LANES; i++) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (!grant_valid && req[l] && (((int'(ptr) + i) % NUM_LANES) == l)) begin
          grant_valid = 1'b1;
          grant[l]    = 1'b1;
          grant_idx   = LANE_IDX_WIDTH'(l);
        end
      end
    end
  end

endmodule

// File: rtl/packet_merger.sv
// Merges byte-wide per-lane packet streams into one AXI4-Stream master,
// one whole packet at a time, with round-robin lane selection.
module packet_merger
  import packet_buffer_pkg::*;
#(
  parameter int AXI_WIDTH   = 64,
  parameter int NUM_LANES   = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [BYTE_WIDTH-1:0]       lane_tdata_i [NUM_LANES],
  input  logic [NUM_LANES-1:0]        lane_tvalid_i,
  input  logic [NUM_LANES-1:0]        lane_tlast_i,
  output logic [NUM_LANES-1:0]        lane_tready_o,
  output logic [AXI_WIDTH-1:0]        tdata_o,
  output logic [AXI_WIDTH/8-1:0]      tkeep_o,
  output logic                        tvalid_o,
  input  logic                        tready_i,
  output logic                        tlast_o,
  output logic [COUNT_WIDTH-1:0]      pkt_count_o,
  output logic                        state_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // valid never waits on ready, and a held beat stays stable until taken.

  localparam int BYTES          = AXI_WIDTH / BYTE_WIDTH;
  localparam int LANE_IDX_WIDTH = $clog2(NUM_LANES);
  localparam int SLOT_WIDTH     = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [SLOT_WIDTH-1:0]     LAST_SLOT = SLOT_WIDTH'(BYTES - 1);
  localparam logic [LANE_IDX_WIDTH-1:0] LAST_LANE = LANE_IDX_WIDTH'(NUM_LANES - 1);

  merger_state_t state_q, state_d;

  logic [LANE_IDX_WIDTH-1:0] grant_idx_q;
  logic [LANE_IDX_WIDTH-1:0] rr_ptr_q;
  logic [LANE_IDX_WIDTH-1:0] arb_idx;
  logic [NUM_LANES-1:0]      arb_grant;
  logic                      arb_valid;

  logic [AXI_WIDTH-1:0]   acc_data_q;
  logic [BYTES-1:0]       acc_keep_q;
  logic [SLOT_WIDTH-1:0]  slot_q;

  logic [AXI_WIDTH-1:0]   tdata_q;
  logic [BYTES-1:0]       tkeep_q;
  logic                   tlast_q;
  logic                   tvalid_q;
  logic [COUNT_WIDTH-1:0] pkt_count_q;

  logic [BYTE_WIDTH-1:0]  in_byte;
  logic                   in_valid;
  logic                   in_last;
  logic                   flush;
  logic                   out_free;
  logic                   accept;
  logic [AXI_WIDTH-1:0]   merged_data;
  logic [BYTES-1:0]       merged_keep;

  rr_arbiter #(
    .NUM_LANES (NUM_LANES)
  ) u_arb (
    .req         (lane_tvalid_i),
    .ptr         (rr_ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_comb begin
    in_byte  = lane_tdata_i[grant_idx_q];
    in_valid = lane_tvalid_i[grant_idx_q];
    in_last  = lane_tlast_i[grant_idx_q];
    // A flushing byte needs room in the output register; other bytes only touch the accumulator.
    flush    = in_last || (slot_q == LAST_SLOT);
    out_free = !tvalid_q || tready_i;

    lane_tready_o = '0;
    if (state_q == XFER) begin
      lane_tready_o[grant_idx_q] = out_free || !flush;
    end
    accept = (state_q == XFER) && in_valid && (out_free || !flush);

    merged_data = acc_data_q;
    merged_keep = acc_keep_q;
    for (int k = 0; k < BYTES; k++) begin
      if (slot_q == SLOT_WIDTH'(k)) begin
        merged_data[byte_slot_lo(k, AXI_WIDTH) +: BYTE_WIDTH] = in_byte;
        merged_keep[BYTES-1-k] = 1'b1;
      end
    end

    state_d = state_q;
    case (state_q)
      IDLE: if (arb_valid) state_d = XFER;
      XFER: if (accept && in_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      acc_data_q  <= '0;
      acc_keep_q  <= '0;
      slot_q      <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && arb_valid) begin
        grant_idx_q <= arb_idx;
      end
      if (accept && in_last) begin
        rr_ptr_q <= (grant_idx_q == LAST_LANE) ? '0 : grant_idx_q + LANE_IDX_WIDTH'(1);
      end

      if (tvalid_q && tready_i) begin
        tvalid_q <= 1'b0;
        if (tlast_q) pkt_count_q <= pkt_count_q + COUNT_WIDTH'(1);
      end

      if (accept) begin
        if (flush) begin
          tdata_q    <= merged_data;
          tkeep_q    <= merged_keep;
          tlast_q    <= in_last;
          tvalid_q   <= 1'b1;
          acc_data_q <= '0;
          acc_keep_q <= '0;
          slot_q     <= '0;
        end else begin
          acc_data_q <= merged_data;
          acc_keep_q <= merged_keep;
          slot_q     <= slot_q + SLOT_WIDTH'(1);
        end
      end
    end
  end

  assign tdata_o     = tdata_q;
  assign tkeep_o     = tkeep_q;
  assign tlast_o     = tlast_q;
  assign tvalid_o    = tvalid_q;
  assign pkt_count_o = pkt_count_q;
  assign state_o     = state_q;

endmodule
